// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared widths, operation codes and FSM states for the divider
package div_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN) + 1;

    // Encoding matches funct3[1:0] of the RV32M divide group.
    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_e;

endpackage

// File: rtl/div_core.sv
// rtl/div_core.sv - unsigned radix-2 restoring shift-subtract engine
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load_i      capture dividend/divisor magnitudes, clear R/Q, cnt = XLEN-1
//   step_i      produce one quotient bit
//   dvd_i       unsigned dividend (used on load)
//   dvs_i       unsigned divisor (captured on load)
//   last_o      the current step is the final one (cnt == 0)
//   quo_o       quotient register
//   rem_o       partial / final remainder register
module div_core
    import div_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] dvd_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic            last_o,
    output logic [XLEN-1:0] quo_o,
    output logic [XLEN-1:0] rem_o
);

    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  dvd_q;
    logic [XLEN-1:0]  dvs_q;
    logic [XLEN-1:0]  quo_q;
    logic [CNT_W-1:0] cnt_q;

    // The stored remainder is always below the divisor, so XLEN bits hold it;
    // the shifted value needs one extra bit or an MSB-set unsigned operand
    // would lose its carry.
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   rem_sub;
    logic            ge;

    assign rem_sh  = {rem_q, dvd_q[XLEN-1]};
    assign ge      = rem_sh >= {1'b0, dvs_q};
    assign rem_sub = rem_sh - {1'b0, dvs_q};

    assign last_o = (cnt_q == '0);
    assign quo_o  = quo_q;
    assign rem_o  = rem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            dvd_q <= '0;
            dvs_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            rem_q <= '0;
            dvd_q <= dvd_i;
            dvs_q <= dvs_i;
            quo_q <= '0;
            cnt_q <= CNT_W'(XLEN - 1);
        end else if (step_i) begin
            rem_q <= ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
            dvd_q <= {dvd_q[XLEN-2:0], 1'b0};
            quo_q <= {quo_q[XLEN-2:0], ge};
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle RV32M DIV/DIVU/REM/REMU unit with sign and special-case wrapper
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       request, honoured only in IDLE
//   div_ctrl    operation (funct3[1:0]): DIV, DIVU, REM, REMU
//   dividend    rs1, sampled with start
//   divisor     rs2, sampled with start
//   flush       abort the operation in flight
//   busy        high in CALC and DONE
//   done        one-cycle pulse, div_out valid
//   div_out     result, held until the next done
module div_unit
    import div_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      div_ctrl,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] div_out
);

    div_state_e      state_q, state_d;
    logic            rem_sel_q, rem_sel_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            special_q, special_d;
    logic [XLEN-1:0] spec_res_q, spec_res_d;
    logic [XLEN-1:0] out_q, out_d;
    logic            done_q, done_d;

    logic            core_load, core_step, core_last;
    logic [XLEN-1:0] core_quo, core_rem;

    div_op_e         op;
    logic            is_signed, is_rem, div_zero, ovf;
    logic [XLEN-1:0] dvd_mag, dvs_mag, quo_fix, rem_fix;

    assign op        = div_op_e'(div_ctrl);
    assign is_signed = (op == DIV) || (op == REM);
    assign is_rem    = (op == REM) || (op == REMU);
    assign div_zero  = (divisor == '0);
    assign ovf       = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}})
                       && (divisor == {XLEN{1'b1}});

    assign dvd_mag = (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
    assign dvs_mag = (is_signed && divisor[XLEN-1])  ? -divisor  : divisor;

    assign quo_fix = neg_quo_q ? -core_quo : core_quo;
    assign rem_fix = neg_rem_q ? -core_rem : core_rem;

    div_core u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (core_load),
        .step_i (core_step),
        .dvd_i  (dvd_mag),
        .dvs_i  (dvs_mag),
        .last_o (core_last),
        .quo_o  (core_quo),
        .rem_o  (core_rem)
    );

    always_comb begin
        state_d    = state_q;
        rem_sel_d  = rem_sel_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        special_d  = special_q;
        spec_res_d = spec_res_q;
        out_d      = out_q;
        done_d     = 1'b0;
        core_load  = 1'b0;
        core_step  = 1'b0;
        case (state_q)
            IDLE: begin
                // A start in the done cycle is refused so done can never
                // pulse on two consecutive cycles.
                if (start && !flush && !done_q) begin
                    rem_sel_d = is_rem;
                    neg_quo_d = is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
                    neg_rem_d = is_signed && dividend[XLEN-1];
                    if (div_zero || ovf) begin
                        special_d = 1'b1;
                        if (div_zero) begin
                            spec_res_d = is_rem ? dividend : {XLEN{1'b1}};
                        end else begin
                            // Overflow quotient equals the dividend (most negative value).
                            spec_res_d = is_rem ? {XLEN{1'b0}} : dividend;
                        end
                        state_d = DONE;
                    end else begin
                        special_d = 1'b0;
                        core_load = 1'b1;
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    core_step = 1'b1;
                    if (core_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    out_d  = special_q ? spec_res_q : (rem_sel_q ? rem_fix : quo_fix);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rem_sel_q  <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            out_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_sel_q  <= rem_sel_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            special_q  <= special_d;
            spec_res_q <= spec_res_d;
            out_q      <= out_d;
            done_q     <= done_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign div_out = out_q;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle integer divider for the RV32M divide/remainder instructions DIV, DIVU, REM and REMU.
- It is the iterative counterpart of the combinational ALU multiplier path and sits beside the ALU in EX.
- The pipeline stalls on busy and captures div_out when done pulses.
- Implementation: radix-2 restoring division, one quotient bit per cycle, with a sign/special-case wrapper.

Parameters:
- XLEN, 32, operand/result width; counter width is $clog2(XLEN)+1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- div_ctrl  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
- dividend  in  XLEN  rs1 value; sampled with start
- divisor  in  XLEN  rs2 value; sampled with start
- flush  in  1  abort the current operation (pipeline kill)
- busy  out  1  high in CALC and DONE
- done  out  1  one-cycle pulse; div_out is valid in that cycle
- div_out  out  XLEN  result; holds its value until the next done

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, div_out=0; all internal registers cleared. Reset takes effect immediately, including mid-operation.
- States and transitions:
  - IDLE: on start, latch div_ctrl, compute the special-case flags, latch the operand magnitudes. Next state is DONE if a special case applies, else CALC.
  - CALC: 33-bit partial remainder R, XLEN-bit quotient Q, counter cnt from XLEN-1 down to 0. Each cycle: R' = {R[XLEN-1:0], dvd_msb}; if R' >= {1'b0, dvs} then R = R' - dvs and shift in 1, else R = R' and shift in 0. After the cnt==0 cycle, go to DONE.
  - DONE: done=1, div_out written; next state IDLE.
- Latency: start sampled at edge k gives done high between edges k+XLEN+1 and k+XLEN+2 (k+33/k+34 for XLEN=32). Special cases give done high between edges k+1 and k+2.
- Signed ops (DIV/REM): operate on magnitudes. Quotient is negated if the operand signs differ. Remainder takes the sign of the dividend. Unsigned ops use raw values.
- Special cases (fast path, no CALC):
  - divisor==0: quotient = all ones, remainder = dividend, for both signed and unsigned.
  - DIV/REM with dividend=0x80000000 and divisor=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- div_out = quotient for DIV/DIVU, remainder for REM/REMU. It is registered and updated only in DONE.
- start while busy is ignored, with no effect on the operation in flight.
- flush in CALC or DONE: IDLE at the next edge, no done pulse, div_out unchanged. flush has priority over the DONE pulse in the same cycle.
- flush with start in IDLE: start is ignored.
- Dividend with MSB=1 under DIVU: full-width unsigned. The 33-bit R prevents a lost carry.
- done is never asserted for two consecutive cycles.

Decomposition:
- Package div_pkg holds:
  - localparam XLEN=32
  - enum div_op_e {DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11}
  - enum div_state_e {IDLE, CALC, DONE}
- One sub-module, div_core: the unsigned shift-subtract engine (R/Q/cnt registers, load/step/last signals).
- div_unit wraps div_core with the FSM, abs/sign fix, special-case detection and output register.

Test Plan:
- DIVU 100/7 -> div_out=14 (0x0000000E), done exactly 33 cycles after start, busy high for 33 cycles. REMU on the same operands -> 2.
- DIV -7/2 (0xFFFFFFF9, 0x00000002) -> 0xFFFFFFFD. REM on the same operands -> 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
- Divide by zero, 0x12345678/0: DIV and DIVU -> 0xFFFFFFFF; REM and REMU -> 0x12345678; done one cycle after start.
- Overflow, DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, both via the fast path.
- Start DIVU 1000/3, flush at CALC cycle 10 -> no done pulse, busy=0 next cycle, div_out unchanged. A new start then completes correctly (333); a start pulsed mid-CALC is ignored.
- Assert rst_n=0 mid-CALC (asynchronously, between edges) -> busy, done and div_out go to 0 immediately. After release, DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
